key_event_bank: RTL and testbench

Parametrised successor to the single-key debouncer. It debounces N_KEYS board pushbuttons or switches in parallel and produces a clean level per key plus single-cycle press, release, long-press and auto-repeat event pulses. It sits between the board top-level KEY/SW pins and the application core. Per-key events drive record/play/stop control, and auto-repeat drives speed adjust.

---
 rtl/key_event_bank.sv | 177 +++++++++++++++++
 tb/tb_key_event_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_bank.sv
// Debounces N_KEYS raw keys and emits clean levels plus
// press/release/long/repeat one-cycle event pulses.
//
// Ports:
//   i_clk        system clock
//   i_rst        async active-high reset
//   i_in         raw key inputs (asynchronous)
//   i_repeat_en  per-key auto-repeat enable
//   o_level      debounced pressed level (1 = pressed)
//   o_press      pulse when o_level rises
//   o_release    pulse when o_level falls
//   o_long       pulse once per press after LONG_CYCLES held
//   o_repeat     pulse every REPEAT_CYCLES after long press
module key_event_bank #(
  parameter int N_KEYS        = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 120000,
  parameter int LONG_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 2400000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_in,
  input  logic [N_KEYS-1:0] i_repeat_en,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HMAX =
    (LONG_CYCLES > REPEAT_CYCLES) ?
    LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HMAX);

  localparam logic [DW-1:0] DEB_TOP =
    DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_TOP =
    HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_TOP =
    HW'(REPEAT_CYCLES - 1);

  // Raw level of a released key, so reset never
  // looks like a press.
  localparam logic REL_BIT = (ACTIVE_LOW != 0);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key

    logic [1:0]    sync_q;
    logic          p;
    logic          diff;
    logic          flip;
    logic          rise;
    logic          fall;
    logic [DW-1:0] deb_q;
    logic          lvl_q;
    logic          press_q;
    logic          rel_q;

    state_t        st_q;
    state_t        st_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          long_d;
    logic          rep_d;
    logic          long_q;
    logic          rep_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sync_q <= {2{REL_BIT}};
      end else begin
        sync_q <= {sync_q[0], i_in[k]};
      end
    end

    assign p    = REL_BIT ? ~sync_q[1] : sync_q[1];
    assign diff = p ^ lvl_q;
    assign flip = diff && (deb_q == DEB_TOP);
    assign rise = flip && !lvl_q;
    assign fall = flip && lvl_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        deb_q   <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        if (!diff || flip) begin
          deb_q <= '0;
        end else begin
          deb_q <= deb_q + 1'b1;
        end
        lvl_q   <= lvl_q ^ flip;
        press_q <= rise;
        rel_q   <= fall;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        st_q   <= IDLE;
        hold_q <= '0;
        long_q <= 1'b0;
        rep_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        hold_q <= hold_d;
        long_q <= long_d;
        rep_q  <= rep_d;
      end
    end

    // A falling level always wins over a terminal
    // count so release never carries long/repeat.
    always_comb begin
      st_d   = st_q;
      hold_d = hold_q;
      long_d = 1'b0;
      rep_d  = 1'b0;
      unique case (st_q)
        IDLE: begin
          if (rise) begin
            st_d   = PRESSED;
            hold_d = '0;
          end
        end
        PRESSED: begin
          if (fall) begin
            st_d   = IDLE;
            hold_d = '0;
          end else if (hold_q == LONG_TOP) begin
            st_d   = HELD;
            hold_d = '0;
            long_d = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            st_d   = IDLE;
            hold_d = '0;
          end else if (!i_repeat_en[k]) begin
            hold_d = '0;
          end else if (hold_q == REP_TOP) begin
            hold_d = '0;
            rep_d  = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: begin
          st_d   = IDLE;
          hold_d = '0;
        end
      endcase
    end

    assign o_level[k]   = lvl_q;
    assign o_press[k]   = press_q;
    assign o_release[k] = rel_q;
    assign o_long[k]    = long_q;
    assign o_repeat[k]  = rep_q;

  end

endmodule

// File: tb/tb_key_event_bank.sv
// Self-checking bench for key_event_bank with a
// time-window model plus directed latency checks.
module tb_key_event_bank;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] kin = '1;
  logic [N-1:0] ren = '0;
  logic [N-1:0] lvl;
  logic [N-1:0] prs;
  logic [N-1:0] rel;
  logic [N-1:0] lng;
  logic [N-1:0] rpt;

  key_event_bank #(
    .N_KEYS       (N),
    .ACTIVE_LOW   (1),
    .DEB_CYCLES   (DEB),
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in       (kin),
    .i_repeat_en(ren),
    .o_level    (lvl),
    .o_press    (prs),
    .o_release  (rel),
    .o_long     (lng),
    .o_repeat   (rpt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, want);
    end
  endtask

  // Model: pq[0] is the pressed-normalised sample
  // taken at this edge; the debouncer acts on
  // samples two edges old, and a level flips once
  // DEB consecutive such samples disagree with it.
  logic [N-1:0] pq [DEB+2];
  logic [N-1:0] m_lvl, m_prs, m_rel, m_lng, m_rpt;
  int  age  [N];
  int  run  [N];
  bit  longd[N];

  task automatic model_reset();
    for (int j = 0; j < DEB + 2; j++) pq[j] = '0;
    m_lvl = '0;
    m_prs = '0;
    m_rel = '0;
    m_lng = '0;
    m_rpt = '0;
    for (int k = 0; k < N; k++) begin
      age[k]   = 0;
      run[k]   = 0;
      longd[k] = 0;
    end
  endtask

  task automatic model_step();
    bit flip;
    m_prs = '0;
    m_rel = '0;
    m_lng = '0;
    m_rpt = '0;
    for (int j = DEB + 1; j > 0; j--) pq[j] = pq[j-1];
    pq[0] = ~kin;
    for (int k = 0; k < N; k++) begin
      flip = 1;
      for (int j = 2; j <= DEB + 1; j++)
        if (pq[j][k] == m_lvl[k]) flip = 0;
      if (flip) begin
        if (m_lvl[k]) m_rel[k] = 1'b1;
        else m_prs[k] = 1'b1;
        m_lvl[k] = ~m_lvl[k];
        age[k]   = 0;
        run[k]   = 0;
        longd[k] = 0;
      end else if (m_lvl[k]) begin
        if (!longd[k]) begin
          age[k]++;
          if (age[k] == LONG) begin
            m_lng[k] = 1'b1;
            longd[k] = 1;
            run[k]   = 0;
          end
        end else begin
          if (ren[k]) run[k]++;
          else run[k] = 0;
          if (run[k] == REP) begin
            m_rpt[k] = 1'b1;
            run[k]   = 0;
          end
        end
      end
    end
  endtask

  int press_cnt[N], last_press[N];
  int rel_cnt[N],   last_rel[N];
  int long_cnt[N],  last_long[N];
  int rep_cnt[N],   last_rep[N];

  initial begin
    model_reset();
    for (int k = 0; k < N; k++) begin
      press_cnt[k] = 0; last_press[k] = 0;
      rel_cnt[k]   = 0; last_rel[k]   = 0;
      long_cnt[k]  = 0; last_long[k]  = 0;
      rep_cnt[k]   = 0; last_rep[k]   = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else model_step();
      #1;
      chk("level",   int'(lvl), int'(m_lvl));
      chk("press",   int'(prs), int'(m_prs));
      chk("release", int'(rel), int'(m_rel));
      chk("long",    int'(lng), int'(m_lng));
      chk("repeat",  int'(rpt), int'(m_rpt));
      for (int k = 0; k < N; k++) begin
        if (prs[k]) begin
          press_cnt[k]++; last_press[k] = cyc;
        end
        if (rel[k]) begin
          rel_cnt[k]++; last_rel[k] = cyc;
        end
        if (lng[k]) begin
          long_cnt[k]++; last_long[k] = cyc;
        end
        if (rpt[k]) begin
          rep_cnt[k]++; last_rep[k] = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int c, p0, ce;

  initial begin
    tick(3);
    chk("reset_zero",
        int'({lvl, prs, rel, lng, rpt}), 0);
    rst = 1'b0;
    tick(10);

    // clean press / short press on key 0
    c = cyc;
    kin[0] = 1'b0;
    tick(10);
    chk("k0_press_lat", last_press[0] - c, 6);
    chk("k0_press_width", press_cnt[0], 1);
    c = cyc;
    kin[0] = 1'b1;
    tick(10);
    chk("k0_rel_lat", last_rel[0] - c, 6);
    chk("k0_short_nolong", long_cnt[0], 0);

    // bounce on key 1
    kin[1] = 1'b0;
    tick(3);
    kin[1] = 1'b1;
    tick(2);
    chk("k1_glitch_quiet",
        press_cnt[1] + rel_cnt[1], 0);
    c = cyc;
    kin[1] = 1'b0;
    tick(10);
    chk("k1_press_lat", last_press[1] - c, 6);
    kin[1] = 1'b1;
    tick(10);

    // long + repeat, release on a repeat boundary
    ren[2] = 1'b1;
    c = cyc;
    kin[2] = 1'b0;
    tick(70);
    kin[2] = 1'b1;
    tick(10);
    p0 = last_press[2];
    chk("k2_press_lat", p0 - c, 6);
    chk("k2_long_at", last_long[2] - p0, 20);
    chk("k2_long_cnt", long_cnt[2], 1);
    chk("k2_rep_cnt", rep_cnt[2], 9);
    chk("k2_last_rep", last_rep[2] - p0, 65);
    chk("k2_rel_at", last_rel[2] - p0, 70);
    ren[2] = 1'b0;

    // repeat disabled, then enabled mid-hold
    c = cyc;
    kin[3] = 1'b0;
    tick(46);
    chk("k3_long_cnt", long_cnt[3], 1);
    chk("k3_no_rep", rep_cnt[3], 0);
    ce = cyc;
    ren[3] = 1'b1;
    tick(7);
    chk("k3_first_rep", last_rep[3] - ce, 5);
    kin[3] = 1'b1;
    ren[3] = 1'b0;
    tick(10);

    // simultaneous press, then reset while held
    c = cyc;
    kin[1:0] = 2'b00;
    tick(8);
    chk("k0_sim_lat", last_press[0] - c, 6);
    chk("k1_sim_lat", last_press[1] - c, 6);
    chk("held_before_rst", int'(lvl), 3);
    rst = 1'b1;
    #1;
    chk("rst_async_zero",
        int'({lvl, prs, rel, lng, rpt}), 0);
    tick(2);
    rst = 1'b0;
    c = cyc;
    tick(8);
    chk("k0_post_rst_lat", last_press[0] - c, 6);
    chk("k1_post_rst_lat", last_press[1] - c, 6);
    kin[1:0] = 2'b11;
    tick(10);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
